// File: rtl/elevator_pkg.sv
// Shared elevator controller constants: floor count, floor index width and
// the default LED minimum on-time used by the call request latch.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS     = 4;
  localparam int unsigned FLOOR_W        = 2;
  localparam int unsigned STRETCH_CYCLES = 250;
  localparam int unsigned CNT_W          = 8;

  typedef logic [FLOOR_W-1:0] floor_t;

endpackage

// File: rtl/pulse_stretcher.sv
// Single-channel minimum on-time generator: a load arms a down-counter and an
// active flag that stays set for STRETCH_CYCLES ticks.
module pulse_stretcher #(
  parameter int unsigned STRETCH_CYCLES = 250,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic active,
  output logic active_next
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next    = cnt;
    active_next = active;
    if (load) begin
      cnt_next    = CNT_W'(STRETCH_CYCLES - 1);
      active_next = 1'b1;
    end else if (active && tick) begin
      // Terminal count drops the flag instead of wrapping the counter.
      if (cnt == '0) active_next = 1'b0;
      else           cnt_next    = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      active <= active_next;
    end
  end

endmodule

// File: rtl/call_request_latch.sv
// Holds per-floor call requests from edge-detected button pulses, drives the
// call LEDs with a minimum lit time and reports the pending set.
module call_request_latch #(
  parameter int unsigned NUM_FLOORS     = elevator_pkg::NUM_FLOORS,
  parameter int unsigned FLOOR_W        = elevator_pkg::FLOOR_W,
  parameter int unsigned STRETCH_CYCLES = elevator_pkg::STRETCH_CYCLES,
  parameter int unsigned CNT_W          = elevator_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req_pulse,
  input  logic                  clear_valid,
  input  logic [FLOOR_W-1:0]    clear_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [NUM_FLOORS-1:0] led,
  output logic                  any_pending,
  output logic [FLOOR_W-1:0]    lowest_pending,
  output logic                  ack_pulse
);

  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] load;
  logic [NUM_FLOORS-1:0] pending_next;
  logic [NUM_FLOORS-1:0] st_next;
  logic [NUM_FLOORS-1:0] st_unused;
  logic                  ack_next;

  // Out-of-range clear_floor matches no channel, so it is ignored naturally.
  always_comb begin
    clr          = '0;
    load         = '0;
    pending_next = '0;
    ack_next     = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      clr[i]          = clear_valid && (clear_floor == FLOOR_W'(i));
      load[i]         = req_pulse[i] && !clr[i];
      pending_next[i] = clr[i] ? 1'b0 : (pending[i] | req_pulse[i]);
      if (load[i] && !pending[i]) ack_next = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_stretch
    pulse_stretcher #(
      .STRETCH_CYCLES (STRETCH_CYCLES),
      .CNT_W          (CNT_W)
    ) u_stretch (
      .clk         (clk),
      .rst         (rst),
      .load        (load[g]),
      .tick        (1'b1),
      .active      (st_unused[g]),
      .active_next (st_next[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending   <= '0;
      led       <= '0;
      ack_pulse <= 1'b0;
    end else begin
      pending   <= pending_next;
      led       <= pending_next | st_next;
      ack_pulse <= ack_next;
    end
  end

  assign any_pending = |pending;

  // Scan from the top so the lowest set bit is the one that sticks.
  always_comb begin
    lowest_pending = '0;
    for (int unsigned i = NUM_FLOORS; i > 0; i--) begin
      if (pending[i-1]) lowest_pending = FLOOR_W'(i - 1);
    end
  end

endmodule

// File: tb/tb_call_request_latch.sv
// Directed bench for call_request_latch: a 4-floor instance with a 5-cycle
// stretch and a 3-floor instance for out-of-range clears.
module tb_call_request_latch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic       cv = 1'b0;
  logic [1:0] cf = '0;
  logic [3:0] pend, led;
  logic       any, ack;
  logic [1:0] low;

  logic [2:0] req3 = '0;
  logic       cv3 = 1'b0;
  logic [1:0] cf3 = '0;
  logic [2:0] pend3, led3;
  logic       any3, ack3;
  logic [1:0] low3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  call_request_latch #(
    .NUM_FLOORS(4), .FLOOR_W(2), .STRETCH_CYCLES(5), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .req_pulse(req), .clear_valid(cv), .clear_floor(cf),
    .pending(pend), .led(led), .any_pending(any), .lowest_pending(low),
    .ack_pulse(ack)
  );

  call_request_latch #(
    .NUM_FLOORS(3), .FLOOR_W(2), .STRETCH_CYCLES(5), .CNT_W(3)
  ) dut3 (
    .clk(clk), .rst(rst), .req_pulse(req3), .clear_valid(cv3), .clear_floor(cf3),
    .pending(pend3), .led(led3), .any_pending(any3), .lowest_pending(low3),
    .ack_pulse(ack3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] ep, input logic [3:0] el,
                      input logic ea, input logic [1:0] elow);
    chk({tag, ".pending"}, 8'(pend), 8'(ep));
    chk({tag, ".led"},     8'(led),  8'(el));
    chk({tag, ".ack"},     8'(ack),  8'(ea));
    chk({tag, ".any"},     8'(any),  8'(|ep));
    chk({tag, ".lowest"},  8'(low),  8'(elow));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with random presses
    for (int i = 0; i < 3; i++) begin
      req = 4'($urandom_range(0, 15));
      tick();
      chk4("rst_hold", 4'b0000, 4'b0000, 1'b0, 2'd0);
    end
    req = '0;
    rst = 1'b1;

    // Single press on floor 2, held, then cleared; LED outlives the clear
    req = 4'b0100;
    tick();                                   // E0
    req = '0;
    chk4("press2", 4'b0100, 4'b0100, 1'b1, 2'd2);
    tick();                                   // E1
    chk4("hold2", 4'b0100, 4'b0100, 1'b0, 2'd2);
    cv = 1'b1; cf = 2'd2;
    tick();                                   // E2
    cv = 1'b0;
    chk4("clr2", 4'b0000, 4'b0100, 1'b0, 2'd0);
    tick(); tick();                           // E3, E4
    chk4("str2_last", 4'b0000, 4'b0100, 1'b0, 2'd0);
    tick();                                   // E5
    chk4("str2_end", 4'b0000, 4'b0000, 1'b0, 2'd0);

    // Press floor 1 and clear it the next cycle: LED lit exactly 5 cycles
    req = 4'b0010;
    tick();                                   // E0
    req = '0; cv = 1'b1; cf = 2'd1;
    chk4("press1", 4'b0010, 4'b0010, 1'b1, 2'd1);
    tick();                                   // E1
    cv = 1'b0;
    chk4("clr1", 4'b0000, 4'b0010, 1'b0, 2'd0);
    tick(); tick(); tick();                   // E2..E4
    chk4("str1_last", 4'b0000, 4'b0010, 1'b0, 2'd0);
    tick();                                   // E5
    chk4("str1_end", 4'b0000, 4'b0000, 1'b0, 2'd0);

    // Set and clear of floor 3 in the same cycle: clear wins, no stretch
    req = 4'b1000; cv = 1'b1; cf = 2'd3;
    tick();
    req = '0; cv = 1'b0;
    chk4("setclr3", 4'b0000, 4'b0000, 1'b0, 2'd0);

    // Two floors in one cycle, then retrigger floor 3
    req = 4'b1001;
    tick();                                   // E0
    req = '0;
    chk4("multi", 4'b1001, 4'b1001, 1'b1, 2'd0);
    tick();                                   // E1
    chk4("multi_hold", 4'b1001, 4'b1001, 1'b0, 2'd0);
    tick(); tick();                           // E2, E3
    req = 4'b1000;
    tick();                                   // E4 retrigger
    req = '0; cv = 1'b1; cf = 2'd0;
    chk4("retrig3", 4'b1001, 4'b1001, 1'b0, 2'd0);
    tick();                                   // E5
    cv = 1'b1; cf = 2'd3;
    chk4("clr0", 4'b1000, 4'b1000, 1'b0, 2'd3);
    tick();                                   // E6: only the reloaded stretch holds led[3]
    cv = 1'b0;
    chk4("clr3", 4'b0000, 4'b1000, 1'b0, 2'd0);
    tick(); tick();                           // E7, E8
    chk4("str3_last", 4'b0000, 4'b1000, 1'b0, 2'd0);
    tick();                                   // E9
    chk4("str3_end", 4'b0000, 4'b0000, 1'b0, 2'd0);

    // Out-of-range and idle clears on the 3-floor instance
    req3 = 3'b100;
    tick();
    req3 = '0; cv3 = 1'b1; cf3 = 2'd3;
    chk("n3_press.pending", 8'(pend3), 8'h04);
    chk("n3_press.ack",     8'(ack3),  8'h01);
    chk("n3_press.lowest",  8'(low3),  8'h02);
    tick();
    cf3 = 2'd0;
    chk("n3_oor.pending", 8'(pend3), 8'h04);
    chk("n3_oor.ack",     8'(ack3),  8'h00);
    chk("n3_oor.any",     8'(any3),  8'h01);
    tick();
    cv3 = 1'b0;
    chk("n3_idle.pending", 8'(pend3), 8'h04);
    chk("n3_idle.ack",     8'(ack3),  8'h00);
    chk("n3_idle.led",     8'(led3),  8'h04);

    // Asynchronous reset mid-stretch with requests pending
    req = 4'b0110;
    tick();
    req = '0;
    chk4("pre_rst", 4'b0110, 4'b0110, 1'b1, 2'd1);
    #2 rst = 1'b0;
    #1;
    chk4("async_rst", 4'b0000, 4'b0000, 1'b0, 2'd0);
    chk("async_rst.n3_pending", 8'(pend3), 8'h00);
    #2 rst = 1'b1;
    tick();
    chk4("post_rst", 4'b0000, 4'b0000, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
